// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-style LCD write controller.
//   state_t      : controller FSM states
//   *_BIT/DB_LSB : bit positions on the 12-bit LCD pin bus
//   CMD_*        : command codes that need the long execute wait
//   is_long_cmd  : true for clear/home commands (RS=0, DB in 0x01..0x03)
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } state_t;

  localparam int DB_LSB = 0;
  localparam int RS_BIT = 8;
  localparam int RW_BIT = 9;
  localparam int EN_BIT = 10;
  localparam int ON_BIT = 11;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
    return !rs && (db == CMD_CLEAR || db == CMD_HOME || db == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// lcd_fifo: small synchronous FIFO holding queued LCD transfers {rs, data}.
//   clk_i, rst_ni : clock, async active-low reset (empties the FIFO)
//   push, wdata   : enqueue request and entry; ignored while full
//   pop, rdata    : dequeue request; rdata shows the head entry
//   empty, full   : derived from the registered occupancy count
module lcd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: queued write-only controller for a parallel character LCD.
//   clk_i, rst_ni : system clock, async active-low reset
//   wr_en_i       : one-cycle request to enqueue a transfer
//   wr_rs_i       : 0 = command, 1 = data
//   wr_data_i     : byte to transfer
//   lcd_on_i      : display power/backlight level, registered to pin 11
//   o_io_lcd      : [7:0] DB, [8] RS, [9] RW (0), [10] EN, [11] ON
//   busy_o        : FIFO non-empty or transfer in progress
//   full_o        : FIFO full
//   ovf_o         : sticky, a write was dropped while full
//
// state | meaning
// IDLE  | waiting; pops head and latches RS/DB when the FIFO has data
// SETUP | RS/DB settling before EN rises, EN=0
// PULSE | EN=1
// HOLD  | RS/DB held after EN falls, EN=0
// EXEC  | waiting for the LCD to execute (long for clear/home)
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLR   = 82000,
  parameter int DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic        wr_rs_i,
  input  logic [7:0]  wr_data_i,
  input  logic        lcd_on_i,
  output logic [11:0] o_io_lcd,
  output logic        busy_o,
  output logic        full_o,
  output logic        ovf_o
);

  localparam int CW = $clog2(T_CLR + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    db;
  logic          rs;
  logic          en;
  logic          on;
  logic          ovf;
  logic [8:0]    head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          last_cycle;

  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign last_cycle = (cnt == CW'(1));

  lcd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (wr_en_i),
    .wdata  ({wr_rs_i, wr_data_i}),
    .pop    (pop),
    .rdata  (head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      cnt   <= '0;
      db    <= '0;
      rs    <= 1'b0;
      en    <= 1'b0;
      on    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      on <= lcd_on_i;
      if (wr_en_i && fifo_full) ovf <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            rs    <= head[8];
            db    <= head[7:0];
            cnt   <= CW'(T_SETUP);
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (last_cycle) begin
            cnt   <= CW'(T_EN);
            en    <= 1'b1;
            state <= ST_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PULSE: begin
          if (last_cycle) begin
            cnt   <= CW'(T_HOLD);
            en    <= 1'b0;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (last_cycle) begin
            cnt   <= is_long_cmd(rs, db) ? CW'(T_CLR) : CW'(T_EXEC);
            state <= ST_EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_EXEC: begin
          if (last_cycle) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          en    <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_io_lcd                 = '0;
    o_io_lcd[DB_LSB +: 8]    = db;
    o_io_lcd[RS_BIT]         = rs;
    o_io_lcd[RW_BIT]         = 1'b0;
    o_io_lcd[EN_BIT]         = en;
    o_io_lcd[ON_BIT]         = on;
  end

  assign busy_o = !fifo_empty || (state != ST_IDLE);
  assign full_o = fifo_full;
  assign ovf_o  = ovf;

endmodule
